lsu_ahb_master: RTL and testbench

//  Load/store unit bus master: converts the processor MEM-stage data request into a single AHB-Lite transfer.

---
 rtl/lsu_ahb_master_pkg.sv | 46 ++++
 rtl/lsu_ahb_master_if.sv | 44 ++++
 rtl/lsu_ahb_master_load_align.sv | 33 +++
 rtl/lsu_ahb_master.sv | 145 ++++++++++++++
 tb/tb_lsu_ahb_master.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ahb_master_pkg.sv
// Shared types and constants for the LSU AHB-Lite master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_ahb_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  // Size code 2'b11 never reaches the bus; it is answered locally with an error.
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // FSM encoding kept as plain constants so older tools can read the state.
  typedef logic [2:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE  = 3'd0;
  localparam lsu_state_t ST_ADDR  = 3'd1;
  localparam lsu_state_t ST_DATA  = 3'd2;
  localparam lsu_state_t ST_ERR   = 3'd3;
  localparam lsu_state_t ST_LOCAL = 3'd4;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Map the processor access size onto the AHB HSIZE encoding.
  function automatic logic [2:0] hsize_of(input logic [1:0] sz);
    logic [2:0] hs;
    case (sz)
      SZ_BYTE: hs = HSIZE_BYTE;
      SZ_HALF: hs = HSIZE_HALF;
      SZ_WORD: hs = HSIZE_WORD;
      default: hs = {1'b0, sz};
    endcase
    return hs;
  endfunction

endpackage

// File: rtl/lsu_ahb_master_if.sv
// Request/response handshake plus AHB-Lite manager signals of the LSU.
// Latency: n/a (wiring only).
// Backpressure: req_ready from the LSU, HREADY from the subordinate.
interface lsu_ahb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] HADDR;
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic [1:0]        HTRANS;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  // LSU side
  modport master (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HSIZE, HWRITE, HWDATA, HTRANS,
    input  HRDATA, HREADY, HRESP
  );

  // Processor + memory side
  modport slave (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HSIZE, HWRITE, HWDATA, HTRANS,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/lsu_ahb_master_load_align.sv
// Extracts the addressed byte/half lane from a 32-bit read word and extends it.
// Latency: combinational.
// Backpressure: none.
module lsu_load_align
  import lsu_ahb_master_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Little-endian lane select followed by sign or zero extension.
  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      SZ_HALF: data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ahb_master.sv
// LSU bus master: one processor load/store -> one AHB-Lite NONSEQ transfer.
// Latency: accept c0, address phase c1, data phase c2, rsp_valid c3 (+1 per HREADY-low cycle).
// Backpressure: req_ready only in IDLE; one transfer outstanding. Macro LSU_MISALIGN_CHECK_EN enables misalign errors.
module lsu_ahb_master
  import lsu_ahb_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)(
  input logic               HCLK,
  input logic               HRESETn,
  lsu_ahb_master_if.master  bus
);

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              accept;
  logic              go_local;
  logic [ADDR_W-1:0] addr_fix;
  logic [DATA_W-1:0] wdata_lanes;
  logic [31:0]       load_data;

  assign accept = bus.req_valid && bus.req_ready;

  // Request decode: which path the request takes, aligned address and replicated store lanes.
  always_comb begin
    addr_fix = bus.req_addr;
    case (bus.req_size)
      SZ_HALF: addr_fix[0]   = 1'b0;
      SZ_WORD: addr_fix[1:0] = 2'b00;
      default: ;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    go_local = (bus.req_size == SZ_RSVD) ||
               ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
               ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    go_local = (bus.req_size == SZ_RSVD);
`endif
    case (bus.req_size)
      SZ_BYTE: wdata_lanes = {4{bus.req_wdata[7:0]}};
      SZ_HALF: wdata_lanes = {2{bus.req_wdata[15:0]}};
      default: wdata_lanes = bus.req_wdata;
    endcase
  end

  // Capture the request; the registers drive the address and data phases directly.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept && !go_local) begin
      addr_q  <= addr_fix;
      size_q  <= bus.req_size;
      write_q <= bus.req_write;
      uns_q   <= bus.req_unsigned;
      wdata_q <= wdata_lanes;
    end
  end

  lsu_load_align u_align (
    .rdata       (bus.HRDATA),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  // Transfer sequencing and the single-cycle response pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (go_local) begin
              // Answered without touching the bus: error reported the cycle after accept.
              state       <= ST_LOCAL;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (bus.HREADY) state <= ST_DATA;
        end
        ST_DATA: begin
          if (bus.HRESP) begin
            if (bus.HREADY) begin
              state       <= ST_IDLE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state <= ST_ERR;
            end
          end else if (bus.HREADY) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b1;
            if (!write_q) rsp_rdata_q <= load_data;
          end
        end
        ST_ERR: begin
          if (bus.HREADY) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        ST_LOCAL: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = HRESETn && (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = addr_q;
  assign bus.HSIZE     = hsize_of(size_q);
  assign bus.HWRITE    = write_q;
  assign bus.HWDATA    = wdata_q;

endmodule

// File: tb/tb_lsu_ahb_master.sv
// Self-checking bench for lsu_ahb_master: directed spec cases then randomized transfers.
// Bench acts as processor and AHB memory; expectations come from a byte-array memory model.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_lsu_ahb_master;
  import lsu_ahb_master_pkg::*;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  byte unsigned mem_b [0:255];

  lsu_ahb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Bus lane j carries store byte (j mod access-width).
  function automatic logic [31:0] exp_lanes(input logic [31:0] wd, input int nb);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      r = r | (((wd >> (8 * (j % nb))) & 32'hFF) << (8 * j));
    return r;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    int base;
    base = int'(a[7:0]) & ~3;
    r = '0;
    for (int k = 0; k < 4; k++) r = r | (32'(mem_b[(base + k) % 256]) << (8 * k));
    return r;
  endfunction

  // Little-endian value of nb bytes at a, extended arithmetically to 32 bits.
  function automatic logic [31:0] exp_load(input logic [31:0] a, input int nb, input bit uns);
    longint unsigned v, lim;
    v = 0;
    for (int i = 0; i < nb; i++) v = v + (longint'(mem_b[(int'(a[7:0]) + i) % 256]) << (8 * i));
    lim = 64'd1 << (8 * nb);
    if (!uns && nb < 4 && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  task automatic mem_store(input logic [31:0] a, input int nb, input logic [31:0] wd);
    for (int i = 0; i < nb; i++) mem_b[(int'(a[7:0]) + i) % 256] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  // One transaction, starting and ending on a falling edge. errmode: 0 ok, 1 two-cycle error, 2 one-cycle error.
  task automatic do_xfer(input string nm, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata, input int nwait, input int errmode,
                         output logic [31:0] got);
    int nb;
    bit loc;
    logic [31:0] a_al;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    loc  = (size == 2'd3) || (CHECK_EN && (addr % nb != 0));
    a_al = addr - (addr % nb);
    got  = '0;
    chk({nm, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_wdata = wdata; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    tick;  // cycle 1
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    if (loc) begin
      chk({nm, "/loc_vld"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, "/loc_err"}, 32'(bus.rsp_err), 32'd1);
      chk({nm, "/loc_rdata"}, bus.rsp_rdata, 32'd0);
      chk({nm, "/loc_htrans"}, 32'(bus.HTRANS), 32'd0);
      got = bus.rsp_rdata;
      tick;
      chk({nm, "/loc_htrans2"}, 32'(bus.HTRANS), 32'd0);
      chk({nm, "/loc_ready"}, 32'(bus.req_ready), 32'd1);
      return;
    end
    chk({nm, "/htrans_nonseq"}, 32'(bus.HTRANS), 32'd2);
    chk({nm, "/haddr"}, bus.HADDR, a_al);
    chk({nm, "/hsize"}, 32'(bus.HSIZE), 32'(size));
    chk({nm, "/hwrite"}, 32'(bus.HWRITE), 32'(wr));
    chk({nm, "/vld_c1"}, 32'(bus.rsp_valid), 32'd0);
    tick;  // cycle 2: data phase
    chk({nm, "/htrans_data"}, 32'(bus.HTRANS), 32'd0);
    if (wr) chk({nm, "/hwdata"}, bus.HWDATA, exp_lanes(wdata, nb));
    if (errmode == 1) begin
      bus.HREADY = 1'b0; bus.HRESP = 1'b1; bus.HRDATA = $urandom;
      tick;
      chk({nm, "/err_wait_vld"}, 32'(bus.rsp_valid), 32'd0);
      bus.HREADY = 1'b1;
      tick;
      bus.HRESP = 1'b0;
      chk({nm, "/err_vld"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, "/err_err"}, 32'(bus.rsp_err), 32'd1);
      chk({nm, "/err_rdata"}, bus.rsp_rdata, 32'd0);
    end else if (errmode == 2) begin
      bus.HREADY = 1'b1; bus.HRESP = 1'b1; bus.HRDATA = $urandom;
      tick;
      bus.HRESP = 1'b0;
      chk({nm, "/err1_vld"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, "/err1_err"}, 32'(bus.rsp_err), 32'd1);
      chk({nm, "/err1_rdata"}, bus.rsp_rdata, 32'd0);
    end else begin
      for (int w = 0; w < nwait; w++) begin
        bus.HREADY = 1'b0; bus.HRDATA = $urandom;
        tick;
        chk({nm, "/wait_haddr"}, bus.HADDR, a_al);
        if (wr) chk({nm, "/wait_hwdata"}, bus.HWDATA, exp_lanes(wdata, nb));
        chk({nm, "/wait_vld"}, 32'(bus.rsp_valid), 32'd0);
        chk({nm, "/wait_htrans"}, 32'(bus.HTRANS), 32'd0);
      end
      bus.HREADY = 1'b1; bus.HRDATA = mem_word(a_al);
      tick;  // response cycle 3 + nwait
      bus.HRDATA = $urandom;
      chk({nm, "/rsp_vld"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, "/rsp_err"}, 32'(bus.rsp_err), 32'd0);
      if (wr) begin
        chk({nm, "/st_rdata"}, bus.rsp_rdata, 32'd0);
        mem_store(a_al, nb, wdata);
      end else begin
        chk({nm, "/ld_rdata"}, bus.rsp_rdata, exp_load(a_al, nb, uns));
      end
    end
    got = bus.rsp_rdata;
    chk({nm, "/ready_rsp"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_unsigned = 1'b0; bus.req_wdata = '0;
    bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);

    // Reset state
    tick; tick;
    chk("rst/htrans", 32'(bus.HTRANS), 32'd0);
    chk("rst/haddr", bus.HADDR, 32'd0);
    chk("rst/hsize", 32'(bus.HSIZE), 32'd0);
    chk("rst/hwrite", 32'(bus.HWRITE), 32'd0);
    chk("rst/hwdata", bus.HWDATA, 32'd0);
    chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tick;

    // Directed cases
    do_xfer("st_word", 1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 0, 0, got);
    do_xfer("ld_sbyte", 1'b0, 32'h101, 2'd0, 1'b0, 32'h0, 0, 0, got);
    chk("ld_sbyte/const", got, 32'hFFFFFFBE);
    do_xfer("ld_uhalf", 1'b0, 32'h102, 2'd1, 1'b1, 32'h0, 0, 0, got);
    chk("ld_uhalf/const", got, 32'h0000DEAD);
    do_xfer("ld_word", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0, 0, got);
    chk("ld_word/const", got, 32'hDEADBEEF);
    do_xfer("ld_wait2", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 2, 0, got);
    do_xfer("st_byte", 1'b1, 32'h105, 2'd0, 1'b0, 32'h000000A5, 1, 0, got);
    do_xfer("st_half", 1'b1, 32'h10A, 2'd1, 1'b0, 32'h00008123, 0, 0, got);
    do_xfer("ld_sbyte2", 1'b0, 32'h105, 2'd0, 1'b0, 32'h0, 0, 0, got);
    do_xfer("ld_shalf", 1'b0, 32'h10A, 2'd1, 1'b0, 32'h0, 0, 0, got);
    do_xfer("err2cyc", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0, 1, got);
    do_xfer("after_err", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0, 0, got);
    do_xfer("err1cyc", 1'b1, 32'h104, 2'd2, 1'b0, 32'h12345678, 0, 2, got);
    do_xfer("h103", 1'b0, 32'h103, 2'd1, 1'b1, 32'h0, 0, 0, got);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("h103/const", got, 32'h0);
`else
    chk("h103/const", got, 32'h0000DEAD);
`endif
    do_xfer("rsvd", 1'b0, 32'h100, 2'd3, 1'b0, 32'h0, 0, 0, got);

    // Reset asserted in the middle of a data phase
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h108; bus.req_size = 2'd2;
    tick;
    bus.req_valid = 1'b0;
    tick;
    bus.HREADY = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst/htrans", 32'(bus.HTRANS), 32'd0);
    chk("mid_rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst/haddr", bus.HADDR, 32'd0);
    tick;
    rst_n = 1'b1; bus.HREADY = 1'b1;
    tick;
    chk("mid_rst/ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst/no_rsp", 32'(bus.rsp_valid), 32'd0);
    do_xfer("post_rst", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0, 0, got);

    // Randomized transfers against the memory model
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      int em;
      sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      em = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_xfer("rnd", 1'($urandom), 32'h100 + 32'($urandom_range(0, 255)), sz, 1'($urandom),
              $urandom, int'($urandom_range(0, 2)), em, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
